// File: rtl/enco_sched.sv
// Round-robin encoder-pulse counter: one shared counter measures rising edges of one channel per window.
// Optional ENCO_SCHED_ZEROHOLD_EN: a zero, non-saturated window reports that channel's last nonzero result.
module enco_sched #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 8,
    parameter int WIN_CYCLES = 131072
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic [NCH-1:0]   enco,
    input  logic             start,
    input  logic [NCH-1:0]   ch_mask,
    output logic [CNT_W-1:0] b,
    output logic [2:0]       b_ch,
    output logic             b_ovf,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             busy
);

    localparam int PW = $clog2(NCH);
    localparam int TW = $clog2(WIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_COUNT,
        S_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  b_q, b_d;
    logic [2:0]        b_ch_q, b_ch_d;
    logic              b_ovf_q, b_ovf_d;
    logic              b_valid_q, b_valid_d;

    logic [NCH-1:0]    sync1_q, sync2_q, prev_q, rise_q;

    logic [PW-1:0]     pick;
    logic              pick_ok;
    logic [CNT_W-1:0]  cnt_nx, rep_cnt;
    logic              ovf_nx;
    logic              win_last;

    // Two synchronizer flops, then edge detect; a pin rise shows on rise_q three edges later.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            rise_q  <= '0;
        end else begin
            sync1_q <= enco;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    // Round-robin search upward from ptr_q+1; descending loop leaves the nearest hit in pick.
    always_comb begin
        int          tmp;
        logic [PW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick    = '0;
        pick_ok = 1'b0;
        tmp     = 0;
        idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            tmp = int'(ptr_q) + k;
            if (tmp >= NCH) tmp = tmp - NCH;
            idx = PW'(tmp);
            if (ch_mask[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_nx = cnt_q;
        ovf_nx = ovf_q;
        if (rise_q[ptr_q]) begin
            if (&cnt_q) ovf_nx = 1'b1;
            else        cnt_nx = cnt_q + CNT_W'(1);
        end
    end

    assign win_last = (state_q == S_COUNT) && (tmr_q == TW'(WIN_CYCLES - 1));

`ifdef ENCO_SCHED_ZEROHOLD_EN
    logic [CNT_W-1:0] hold_q [NCH];

    // NOTE: the hold registers are reset because a zero window right after reset must report 0, not stale data.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
        end else if (win_last && (cnt_nx != '0)) begin
            hold_q[ptr_q] <= cnt_nx;
        end
    end

    assign rep_cnt = ((cnt_nx == '0) && !ovf_nx) ? hold_q[ptr_q] : cnt_nx;
`else
    assign rep_cnt = cnt_nx;
`endif

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ptr_q     <= PW'(NCH - 1);
            b_q       <= '0;
            b_ch_q    <= '0;
            b_ovf_q   <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            b_q       <= b_d;
            b_ch_q    <= b_ch_d;
            b_ovf_q   <= b_ovf_d;
            b_valid_q <= b_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        ptr_d     = ptr_q;
        b_d       = b_q;
        b_ch_d    = b_ch_q;
        b_ovf_d   = b_ovf_q;
        b_valid_d = b_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (ch_mask != '0)) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (pick_ok) begin
                    ptr_d   = pick;
                    tmr_d   = '0;
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                // Mux just switched: edges seen here belong to the flush, not the window.
                cnt_d = '0;
                ovf_d = 1'b0;
                if (tmr_q == TW'(2)) begin
                    tmr_d   = '0;
                    state_d = S_COUNT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_COUNT: begin
                cnt_d = cnt_nx;
                ovf_d = ovf_nx;
                if (win_last) begin
                    b_d       = rep_cnt;
                    b_ch_d    = 3'(ptr_q);
                    b_ovf_d   = ovf_nx;
                    b_valid_d = 1'b1;
                    state_d   = S_REPORT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_REPORT: begin
                if (b_valid_q && b_ready) begin
                    b_valid_d = 1'b0;
                    state_d   = start ? S_SELECT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign b       = b_q;
    assign b_ch    = b_ch_q;
    assign b_ovf   = b_ovf_q;
    assign b_valid = b_valid_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_enco_sched.sv
// Scoreboard bench for enco_sched: stimulus pushes expected results, a negedge monitor pops on each handshake.
module tb_enco_sched;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    // Long enough to fit 300 synchronised pulses (each needs a high and a low sample) in one window.
    localparam int WIN   = 700;

    logic             clk1 = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   enco;
    logic             start;
    logic [NCH-1:0]   ch_mask;
    logic [CNT_W-1:0] b;
    logic [2:0]       b_ch;
    logic             b_ovf;
    logic             b_valid;
    logic             b_ready;
    logic             busy;

    enco_sched #(.NCH(NCH), .CNT_W(CNT_W), .WIN_CYCLES(WIN)) dut (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .enco    (enco),
        .start   (start),
        .ch_mask (ch_mask),
        .b       (b),
        .b_ch    (b_ch),
        .b_ovf   (b_ovf),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .busy    (busy)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int ch;
        int cnt;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

`ifdef ENCO_SCHED_ZEROHOLD_EN
    localparam int ZERO_WIN_EXP = 7;
`else
    localparam int ZERO_WIN_EXP = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int cnt, input int ovf);
        exp_t e;
        e.ch  = ch;
        e.cnt = cnt;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic pulses(input logic [1:0] ch, input int n);
        repeat (n) begin
            @(posedge clk1); #1 enco[ch] = 1'b1;
            @(posedge clk1); #1 enco[ch] = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (b_valid !== 1'b1 && n < 2000);
        if (b_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: b_valid timeout, got 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Monitor: each accepted result is compared against the head of the scoreboard.
    always @(negedge clk1) begin
        if (rst_n === 1'b1 && b_valid === 1'b1 && b_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got ch=%0d b=%0d, expected no result", b_ch, b);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_ch",  int'(b_ch),  mon_e.ch);
                check("result_b",   int'(b),     mon_e.cnt);
                check("result_ovf", int'(b_ovf), mon_e.ovf);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk1);
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        enco    = '0;
        start   = 1'b0;
        ch_mask = '0;
        b_ready = 1'b1;
        step(3);
        @(negedge clk1);
        check("rst_b",       int'(b),       0);
        check("rst_b_ch",    int'(b_ch),    0);
        check("rst_b_ovf",   int'(b_ovf),   0);
        check("rst_b_valid", int'(b_valid), 0);
        check("rst_busy",    int'(busy),    0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Rotation over ch0/ch2; ch1 is pulsed but masked off.
        ch_mask = 4'b0101;
        start   = 1'b1;
        push(0, 10, 0);
        push(2, 3, 0);
        push(0, 10, 0);
        step(20);
        fork
            pulses(2'd0, 10);
            pulses(2'd1, 7);
        join
        @(negedge clk1);
        check("busy_in_window", int'(busy), 1);
        wait_valid("win1");
        step(1);
        step(20);
        pulses(2'd2, 3);
        wait_valid("win2");
        step(1);
        step(20);
        pulses(2'd0, 10);
        ch_mask = 4'b0010;   // mid-window; applies at the next SELECT only
        push(1, 255, 1);
        wait_valid("win3");
        step(1);

        // Saturation.
        step(20);
        pulses(2'd1, 300);
        wait_valid("win4");
        step(1);

        // Back-pressure: result must hold while b_ready is low.
        step(20);
        pulses(2'd1, 5);
        push(1, 5, 0);
        b_ready = 1'b0;
        wait_valid("win5");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk1);
            check("hold_b",       int'(b),       5);
            check("hold_b_ch",    int'(b_ch),    1);
            check("hold_b_valid", int'(b_valid), 1);
        end
        @(posedge clk1); #1 b_ready = 1'b1;
        @(posedge clk1); #1;
        @(negedge clk1);
        check("valid_drop", int'(b_valid), 0);

        // start dropped mid-COUNT: window still reports, then IDLE.
        step(20);
        pulses(2'd1, 4);
        start = 1'b0;
        push(1, 4, 0);
        wait_valid("win6");
        step(1);
        step(3);
        @(negedge clk1);
        check("idle_busy",  int'(busy),    0);
        check("idle_valid", int'(b_valid), 0);

        // Empty mask never leaves IDLE.
        ch_mask = 4'b0000;
        start   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk1);
            check("nomask_busy",  int'(busy),    0);
            check("nomask_valid", int'(b_valid), 0);
        end

        // Reset mid-COUNT on ch2 discards the window; next pick restarts at ch0.
        ch_mask = 4'b0101;
        step(20);
        pulses(2'd2, 3);
        rst_n = 1'b0;
        step(1);
        @(negedge clk1);
        check("midrst_b",       int'(b),       0);
        check("midrst_b_ch",    int'(b_ch),    0);
        check("midrst_b_ovf",   int'(b_ovf),   0);
        check("midrst_b_valid", int'(b_valid), 0);
        check("midrst_busy",    int'(busy),    0);
        rst_n = 1'b1;
        push(0, 6, 0);
        step(20);
        pulses(2'd0, 6);
        ch_mask = 4'b0001;
        wait_valid("win7");
        step(1);

        // Zero-hold: 7 edges, then an empty window on ch0.
        step(20);
        pulses(2'd0, 7);
        push(0, 7, 0);
        wait_valid("win8");
        step(1);
        step(20);
        pulses(2'd2, 5);
        start = 1'b0;
        push(0, ZERO_WIN_EXP, 0);
        wait_valid("win9");
        step(1);
        step(5);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
